// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: quotient to LO path, remainder to HI path.
// One quotient bit per cycle; start accepted only in IDLE, done pulses 34 cycles later (1 for divide-by-zero).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] div_high_out,
  output logic [WIDTH-1:0] div_low_out,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             neg_a, neg_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             trial_ge;

  assign neg_a    = !is_unsigned && dividend[WIDTH-1];
  assign neg_b    = !is_unsigned && divisor[WIDTH-1];
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  // When the trial fits (shifted >= divisor), the difference is below 2^WIDTH.
  assign trial_ge = shifted >= {1'b0, dvs_q};
  assign trial    = shifted[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            sgnq_d  = neg_a ^ neg_b;
            sgnr_d  = neg_a;
            quo_d   = neg_a ? -dividend : dividend;
            dvs_d   = neg_b ? -divisor : divisor;
            rem_d   = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (trial_ge) begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = sgnq_q ? -quo_q : quo_q;
        hi_d    = sgnr_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign div_high_out = hi_q;
  assign div_low_out  = lo_q;
  assign div_zero     = dz_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero, start-while-busy, async reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_unsigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] div_high_out;
  logic [31:0] div_low_out;
  logic        div_zero;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_unsigned  (is_unsigned),
    .dividend     (dividend),
    .divisor      (divisor),
    .div_high_out (div_high_out),
    .div_low_out  (div_low_out),
    .div_zero     (div_zero),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge (edge 0), then scrambles operands to prove they were latched.
  task automatic launch(input logic u, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start       = 1'b1;
    is_unsigned = u;
    dividend    = a;
    divisor     = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Called #1 after edge 0; observes cycles after edges 0..44. Optionally pulses start (50/5) at edge inj.
  task automatic wait_done(input int inj, output int lat, output int pulses, output int busy_low);
    lat = -1; pulses = 0; busy_low = 0;
    for (int n = 0; n < 45; n++) begin
      if (done) begin
        pulses++;
        if (lat < 0) lat = n;
      end
      if (lat < 0 && !busy) busy_low++;
      if (n + 1 == inj) begin
        @(negedge clk);
        start = 1'b1; is_unsigned = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic u, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat,
                        input logic exp_dz);
    int lat, pulses, busy_low;
    launch(u, a, b);
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    wait_done(0, lat, pulses, busy_low);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_busy"}, busy_low, 32'd0);
    check({tag, "_lo"}, div_low_out, exp_lo);
    check({tag, "_hi"}, div_high_out, exp_hi);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, pulses, busy_low;
    reset = 1'b1; start = 1'b0; is_unsigned = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst_hi",   div_high_out, 32'd0);
    check("rst_lo",   div_low_out, 32'd0);
    check("rst_dz",   {31'd0, div_zero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("u100_7",  1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    run_op("divzero", 1'b0, 32'd5,   32'd0, 32'd14, 32'd2, 0,  1'b1);
    run_op("u9_3",    1'b1, 32'd9,   32'd3, 32'd3,  32'd0, 33, 1'b0);
    run_op("s_m7_2",  1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("s_7_m2",  1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33, 1'b0);
    run_op("s_m7_m2", 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("s_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33, 1'b0);
    run_op("u_max_2", 1'b1, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'd1,         33, 1'b0);
    run_op("u5_9",    1'b1, 32'd5,         32'd9,         32'd0,         32'd5,         33, 1'b0);

    // Start pulse at edge 10 during a 100/7 must be dropped.
    launch(1'b1, 32'd100, 32'd7);
    wait_done(10, lat, pulses, busy_low);
    check("busy_ign_lat",    lat, 32'd33);
    check("busy_ign_pulses", pulses, 32'd1);
    check("busy_ign_lo",     div_low_out, 32'd14);
    check("busy_ign_hi",     div_high_out, 32'd2);
    run_op("u50_5", 1'b1, 32'd50, 32'd5, 32'd10, 32'd0, 33, 1'b0);

    // Leave nonzero outputs, then reset in the middle of a 100/7.
    run_op("pre_rst", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
    launch(1'b1, 32'd100, 32'd7);
    pulses = 0;
    for (int n = 1; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_lo",   div_low_out, 32'd0);
    check("midrst_hi",   div_high_out, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("midrst_nodone", pulses, 32'd0);
    run_op("post_rst", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
